// File: rtl/rvv_line_mem_responder.sv
// ============================================================================
// Module   : rvv_line_mem_responder
// Brief    : Line-granular backing memory answering each request after a fixed
//            LATENCY. Optional define RVV_MEM_RESP_BOUNDS_CHECK_EN flags
//            out-of-range addresses on mem_err instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvv_line_mem_responder #(
    parameter int CACHE_LINE_WIDTH = 512,
    parameter int DEPTH            = 1024,
    parameter int LATENCY          = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_read_en,
    input  logic                        mem_write_en,
    input  logic [31:0]                 mem_addr,
    input  logic [CACHE_LINE_WIDTH-1:0] mem_write_data,
    output logic                        mem_ready,
    output logic [CACHE_LINE_WIDTH-1:0] mem_read_data,
    output logic                        mem_err
);

    localparam int c_OFFSET = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int c_IDX    = $clog2(DEPTH);
    localparam int c_CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [c_CNT_W-1:0]          cnt_q, cnt_d;
    logic [c_IDX-1:0]            idx_q, idx_d;
    logic [CACHE_LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                        is_wr_q, is_wr_d;
    logic                        oor_q, oor_d;
    logic                        ready_q, ready_d;
    logic                        err_q, err_d;
    logic [CACHE_LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                        w_mem_we;
    logic                        w_enter_resp;
    logic                        w_oor_in;
    logic                        w_addr_unused;

    logic [CACHE_LINE_WIDTH-1:0] r_mem [DEPTH];

`ifdef RVV_MEM_RESP_BOUNDS_CHECK_EN
    assign w_oor_in = |mem_addr[31:c_OFFSET+c_IDX];
`else
    assign w_oor_in = 1'b0;
`endif

    assign w_addr_unused = ^{mem_addr[31:c_OFFSET+c_IDX], mem_addr[c_OFFSET-1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        is_wr_d      = is_wr_q;
        oor_d        = oor_q;
        ready_d      = 1'b0;
        err_d        = 1'b0;
        rdata_d      = rdata_q;
        w_mem_we     = 1'b0;
        w_enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_read_en || mem_write_en) begin
                    idx_d   = mem_addr[c_OFFSET+c_IDX-1:c_OFFSET];
                    wdata_d = mem_write_data;
                    is_wr_d = mem_write_en;
                    oor_d   = w_oor_in;
                    cnt_d   = c_CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d      = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - c_CNT_W'(1);
                if (cnt_q == c_CNT_W'(1)) begin
                    state_d      = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The *_d request fields already select live inputs when LATENCY is 1.
        if (w_enter_resp) begin
            ready_d = 1'b1;
            err_d   = oor_d;
            if (oor_d) begin
                rdata_d = '0;
            end else if (is_wr_d) begin
                rdata_d  = wdata_d;
                w_mem_we = 1'b1;
            end else begin
                rdata_d = r_mem[idx_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            oor_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            oor_q   <= oor_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[idx_d] <= wdata_d;
        end
    end

    assign mem_ready     = ready_q;
    assign mem_read_data = rdata_q;
    assign mem_err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rvv_line_mem_responder.sv
// ============================================================================
// Module   : tb_rvv_line_mem_responder
// Brief    : Directed scoreboard bench for rvv_line_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvv_line_mem_responder;

    localparam int W  = 512;
    localparam int W1 = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd, wr;
    logic [31:0]   addr;
    logic [W-1:0]  wdata;
    logic          ready;
    logic [W-1:0]  rdata;
    logic          err;

    logic          rd1, wr1;
    logic [31:0]   addr1;
    logic [W1-1:0] wdata1;
    logic          ready1;
    logic [W1-1:0] rdata1;
    logic          err1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rvv_line_mem_responder #(
        .CACHE_LINE_WIDTH(W), .DEPTH(1024), .LATENCY(4)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_read_en(rd), .mem_write_en(wr), .mem_addr(addr),
        .mem_write_data(wdata),
        .mem_ready(ready), .mem_read_data(rdata), .mem_err(err)
    );

    rvv_line_mem_responder #(
        .CACHE_LINE_WIDTH(W1), .DEPTH(16), .LATENCY(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .mem_read_en(rd1), .mem_write_en(wr1), .mem_addr(addr1),
        .mem_write_data(wdata1),
        .mem_ready(ready1), .mem_read_data(rdata1), .mem_err(err1)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, W'(1), W'(0));
        end else begin
            x = sb.pop_front();
            chk({tag, "_data"}, rdata, x.data);
            chk({tag, "_err"}, W'(err), W'(x.err));
        end
    endtask

    // One request on the LATENCY=4 instance; called at a falling edge.
    task automatic req(input logic r, input logic w, input logic [31:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] exp_d,
                       input logic exp_e, input string tag);
        int lat;
        push_exp(exp_d, exp_e);
        rd = r; wr = w; addr = a; wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready && lat < 20);
        rd = 1'b0; wr = 1'b0;
        chk({tag, "_lat"}, W'(lat), W'(4));
        if (ready) pop_check(tag);
        else void'(sb.pop_front());
        @(negedge clk);
        chk({tag, "_width"}, W'(ready), '0);
    endtask

    initial begin
        int t, n, last;

        rst = 1'b1;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", W'(ready), '0);
            chk("idle_err", W'(err), '0);
            chk("idle_rdata", rdata, '0);
        end

        // Round trip; offset bits of the address are ignored
        req(1'b0, 1'b1, 32'h40, {64{8'hA5}}, {64{8'hA5}}, 1'b0, "wr40");
        req(1'b1, 1'b0, 32'h40, '0, {64{8'hA5}}, 1'b0, "rd40");
        req(1'b1, 1'b0, 32'h41, '0, {64{8'hA5}}, 1'b0, "rd41");

        // Read+write together behaves as a write
        req(1'b1, 1'b1, 32'h80, W'(16'h1234), W'(16'h1234), 1'b0, "rw80");
        req(1'b1, 1'b0, 32'h80, '0, W'(16'h1234), 1'b0, "rd80");

        // Held read: pulses every LATENCY+1 cycles
        req(1'b0, 1'b1, 32'h200, {64{8'h5A}}, {64{8'h5A}}, 1'b0, "wr200");
        repeat (3) push_exp({64{8'h5A}}, 1'b0);
        rd = 1'b1; addr = 32'h200;
        t = 0; n = 0; last = 0;
        while (n < 3 && t < 40) begin
            @(negedge clk);
            t++;
            if (ready) begin
                pop_check("b2b");
                if (n == 0) chk("b2b_first_lat", W'(t), W'(4));
                else        chk("b2b_gap", W'(t - last), W'(5));
                last = t;
                n++;
                if (n == 3) rd = 1'b0;
            end
        end
        rd = 1'b0;
        sb.delete();
        chk("b2b_count", W'(n), W'(3));
        @(negedge clk);
        chk("b2b_tail", W'(ready), '0);

        // LATENCY=1 instance: 1-cycle latency and pulses every 2 cycles
        wr1 = 1'b1; addr1 = 32'h8; wdata1 = 64'hCAFE_F00D_1234_5678;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ready1 && t < 10);
        wr1 = 1'b0;
        chk("l1_wr_lat", W'(t), W'(1));
        chk("l1_wr_data", W'(rdata1), W'(64'hCAFE_F00D_1234_5678));
        @(negedge clk);
        rd1 = 1'b1;
        t = 0; n = 0; last = 0;
        while (n < 3 && t < 20) begin
            @(negedge clk);
            t++;
            if (ready1) begin
                chk("l1_rd_data", W'(rdata1), W'(64'hCAFE_F00D_1234_5678));
                if (n == 0) chk("l1_first_lat", W'(t), W'(1));
                else        chk("l1_gap", W'(t - last), W'(2));
                last = t;
                n++;
                if (n == 3) rd1 = 1'b0;
            end
        end
        rd1 = 1'b0;
        chk("l1_count", W'(n), W'(3));

        // Reset two cycles into a write aborts it
        req(1'b0, 1'b1, 32'h100, {64{8'h3C}}, {64{8'h3C}}, 1'b0, "wr100");
        wr = 1'b1; addr = 32'h100; wdata = {64{8'hFF}};
        repeat (2) @(negedge clk);
        rst = 1'b1; wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_ready", W'(ready), '0);
        end
        chk("abort_rdata", rdata, '0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_post_ready", W'(ready), '0);
        end
        req(1'b1, 1'b0, 32'h100, '0, {64{8'h3C}}, 1'b0, "rd100");

`ifdef RVV_MEM_RESP_BOUNDS_CHECK_EN
        req(1'b0, 1'b1, 32'h0, {64{8'h77}}, {64{8'h77}}, 1'b0, "wr0");
        req(1'b0, 1'b1, 32'h0001_0000, {16{32'hDEAD_BEEF}}, '0, 1'b1, "wr_oor");
        req(1'b1, 1'b0, 32'h0, '0, {64{8'h77}}, 1'b0, "rd0");
`else
        req(1'b0, 1'b1, 32'h0001_0000, {16{32'hDEAD_BEEF}}, {16{32'hDEAD_BEEF}}, 1'b0, "wr_wrap");
        req(1'b1, 1'b0, 32'h0, '0, {16{32'hDEAD_BEEF}}, 1'b0, "rd0");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
